pc_redirect_unit: RTL and testbench

//   Parametrised fetch program counter for the 5-stage pipeline.

---
 rtl/pc_redirect_unit_if.sv | 24 ++
 rtl/pc_redirect_unit.sv | 74 +++++++
 tb/tb_pc_redirect_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_if.sv
// Fetch-PC interface: hazard/MEM-stage controls in, fetch PC and flush/trap status out.
interface pc_redirect_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             PCWrite;
  logic             Redirect;
  logic [WIDTH-1:0] RedirectTarget;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlusInc;
  logic             Flush;
  logic             RedirectPending;
  logic             Trap;
  logic [WIDTH-1:0] EPC;

  modport master (
    output PCWrite, Redirect, RedirectTarget,
    input  PCResult, PCPlusInc, Flush, RedirectPending, Trap, EPC
  );

  modport slave (
    input  PCWrite, Redirect, RedirectTarget,
    output PCResult, PCPlusInc, Flush, RedirectPending, Trap, EPC
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch program counter with stall-tolerant branch/jump redirect and misaligned-target trap.
module pc_redirect_unit #(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h80),
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input logic               Clk,
  input logic               Reset,
  pc_redirect_unit_if.slave bus
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pending_target;
  logic [WIDTH-1:0] epc;
  logic             pending;
  logic             flush;
  logic             trap;
  logic             misaligned_c;

  // A zero-width alignment field disables the trap entirely.
  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign misaligned_c = 1'b0;
    end else begin : g_align
      assign misaligned_c = bus.Redirect && (bus.RedirectTarget[ALIGN_BITS-1:0] != '0);
    end
  endgenerate

  // Rules are prioritised: trap, redirect, stalled redirect, pending release, advance, hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc             <= RESET_VECTOR;
      pending_target <= '0;
      epc            <= '0;
      pending        <= 1'b0;
      flush          <= 1'b0;
      trap           <= 1'b0;
    end else begin
      flush <= 1'b0;
      trap  <= 1'b0;
      if (misaligned_c) begin
        pc      <= TRAP_VECTOR;
        epc     <= bus.RedirectTarget;
        trap    <= 1'b1;
        flush   <= 1'b1;
        pending <= 1'b0;
      end else if (bus.Redirect && bus.PCWrite) begin
        pc      <= bus.RedirectTarget;
        flush   <= 1'b1;
        pending <= 1'b0;
      end else if (bus.Redirect) begin
        pending_target <= bus.RedirectTarget;
        pending        <= 1'b1;
        flush          <= 1'b1;
      end else if (pending && bus.PCWrite) begin
        // Pipeline was already squashed when the redirect was captured.
        pc      <= pending_target;
        pending <= 1'b0;
      end else if (bus.PCWrite) begin
        pc <= pc + WIDTH'(INC);
      end
    end
  end

  assign bus.PCResult        = pc;
  assign bus.PCPlusInc       = pc + WIDTH'(INC);
  assign bus.Flush           = flush;
  assign bus.RedirectPending = pending;
  assign bus.Trap            = trap;
  assign bus.EPC             = epc;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed and randomized checks of pc_redirect_unit against an in-bench behavioural model.
module tb_pc_redirect_unit;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_miss;

  // Behavioural model state
  logic [31:0] m_pc, m_ptgt, m_epc;
  logic        m_pend, m_flush, m_trap;

  pc_redirect_unit_if #(.WIDTH(32)) bus ();

  pc_redirect_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .TRAP_VECTOR(32'h80), .ALIGN_BITS(2)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ptgt = 32'h0; m_epc = 32'h0;
    m_pend = 1'b0; m_flush = 1'b0; m_trap = 1'b0;
  endtask

  // Next state straight from the rule list; the fetch PC is a 32-bit value that wraps.
  task automatic model_edge();
    logic        pcw, red, mis;
    logic [31:0] tgt;
    pcw = bus.PCWrite; red = bus.Redirect; tgt = bus.RedirectTarget;
    mis = red && (tgt % 4 != 0);
    m_flush = 1'b0;
    m_trap  = 1'b0;
    if (mis) begin
      m_pc = 32'h80; m_epc = tgt; m_trap = 1'b1; m_flush = 1'b1; m_pend = 1'b0;
    end else if (red && pcw) begin
      m_pc = tgt; m_flush = 1'b1; m_pend = 1'b0;
    end else if (red) begin
      m_ptgt = tgt; m_pend = 1'b1; m_flush = 1'b1;
    end else if (m_pend && pcw) begin
      m_pc = m_ptgt; m_pend = 1'b0;
    end else if (pcw) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    check("PCResult",        bus.PCResult,               m_pc);
    check("PCPlusInc",       bus.PCPlusInc,              m_pc + 32'd4);
    check("Flush",           32'(bus.Flush),             32'(m_flush));
    check("RedirectPending", 32'(bus.RedirectPending),   32'(m_pend));
    check("Trap",            32'(bus.Trap),              32'(m_trap));
    check("EPC",             bus.EPC,                    m_epc);
  endtask

  // Apply one cycle of inputs; optionally pulse Reset between edges; check #1 after the edge.
  task automatic step(input logic pcw, input logic red, input logic [31:0] tgt, input logic rst_mid);
    bus.PCWrite = pcw; bus.Redirect = red; bus.RedirectTarget = tgt;
    if (rst_mid) begin
      #2 Reset = 1'b1;
      #1 model_reset();
      compare_all();
      #1 Reset = 1'b0;
    end
    @(posedge Clk);
    model_edge();
    #1 compare_all();
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    bus.PCWrite = 1'b0; bus.Redirect = 1'b0; bus.RedirectTarget = 32'h0;
    Reset = 1'b1;
    model_reset();
    #12;
    compare_all();
    check("reset_pc_literal", bus.PCResult, 32'h0);
    Reset = 1'b0;
    #1;

    // T1: sequential fetch from the reset vector
    step(1'b1, 1'b0, 32'h0, 1'b0); check("T1_pc4",  bus.PCResult, 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b0); check("T1_pc8",  bus.PCResult, 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b0); check("T1_pc12", bus.PCResult, 32'hC);
    check("T1_flush", 32'(bus.Flush), 32'h0);

    // T2: redirect accepted immediately, single-cycle flush
    step(1'b1, 1'b1, 32'h100, 1'b0);
    check("T2_pc", bus.PCResult, 32'h100);
    check("T2_flush", 32'(bus.Flush), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("T2_flush_drop", 32'(bus.Flush), 32'h0);

    // T3: redirect captured during stall, applied when stall lifts
    step(1'b1, 1'b1, 32'h40, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b0);
    check("T3_hold", bus.PCResult, 32'h40);
    check("T3_pend", 32'(bus.RedirectPending), 32'h1);
    check("T3_flush", 32'(bus.Flush), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("T3_still_hold", bus.PCResult, 32'h40);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("T3_apply", bus.PCResult, 32'h200);
    check("T3_pend_clr", 32'(bus.RedirectPending), 32'h0);
    check("T3_no_flush", 32'(bus.Flush), 32'h0);

    // T4: misaligned target traps even while stalled
    step(1'b0, 1'b1, 32'h102, 1'b0);
    check("T4_pc", bus.PCResult, 32'h80);
    check("T4_epc", bus.EPC, 32'h102);
    check("T4_trap", 32'(bus.Trap), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("T4_trap_drop", 32'(bus.Trap), 32'h0);

    // T5: wrap at the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("T5_wrap", bus.PCResult, 32'h0);
    check("T5_plus", bus.PCPlusInc, 32'h4);

    // T6: reset between edges discards a pending redirect
    step(1'b0, 1'b1, 32'h300, 1'b0);
    check("T6_pend", 32'(bus.RedirectPending), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("T6_after", bus.PCResult, 32'h4);

    // Randomized traffic, mostly aligned targets, occasional mid-cycle reset
    for (int i = 0; i < 400; i++) begin
      logic        pcw, red, rm;
      logic [31:0] tgt;
      pcw = ($urandom_range(0, 3) != 0);
      red = ($urandom_range(0, 4) == 0);
      tgt = $urandom();
      if ($urandom_range(0, 5) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 30) == 0) tgt = 32'hFFFF_FFFC;
      rm  = ($urandom_range(0, 60) == 0);
      step(pcw, red, tgt, rm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
